priority_mux_arbiter: RTL and testbench
=======================================

# priority_mux_arbiter

- Shares one 6-to-1 priority-mux datapath among six requesters.
- Each cycle it may pick one winner, drive the one-hot mux select for it, and capture the winner's word into an output register.
- It then holds that word under a valid/ready handshake until the consumer takes it.
- It sits in front of the priority mux chain and replaces hand-driven `sel` lines with an arbitrated, flow-controlled stream.

## Interface
Parameters:
- `WIDTH`, 8, data word width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  6  request per source; `req[i]` means `d_i` holds a valid word.
- `d0`..`d5`  in  `WIDTH` each  source data words.
- `gnt`  out  6  combinational one-hot grant; `gnt[i]` high in the cycle `d_i` is captured.
- `sel`  out  5  registered mux select for the held word: winner 0 gives `5'b00000`, winner k>0 gives `1<<(k-1)`.
- `gnt_id`  out  3  registered index (0..5) of the source of the held word.
- `out_valid`  out  1  `d_out` holds an unconsumed word.
- `out_ready`  in  1  consumer accepts `d_out` this cycle.
- `d_out`  out  `WIDTH`  held word.

## Operation
- FSM states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Load condition: `load = |req && (state==EMPTY || out_ready)`.
  - `load` is high and `rst_n` is high: `gnt` = one-hot winner; otherwise `gnt` = 0.
  - On `load`: `d_out`<=`d_w`, `gnt_id`<=w, `sel`<=code(w), state<=FULL.
- FULL && `out_ready` && no `req`: state<=EMPTY; `d_out`/`gnt_id`/`sel` keep their last values.
- FULL && !`out_ready`:
  - Registers are frozen and `gnt` = 0, regardless of `req`.
  - No source is granted while the output is stalled.
- Back-to-back transfer: in FULL with `out_ready` and any `req`, the consume and the new load happen in the same cycle. This gives one word per cycle.
- Winner selection (fixed priority, default): highest requesting index wins (5 > 4 > ... > 0). This matches the mux chain's precedence.
- Datapath: the winning word is selected inside the block. The block uses the same priority-chain semantics, so a word loaded under `sel` equals what the external mux chain outputs for that `sel`.
- Requester contract:
  - After seeing `gnt[i]`, a source either deasserts `req[i]` or presents its next word in the following cycle.
  - `req` need not be held stable while ungranted.

## Timing
- Reset values: `out_valid`=0, `d_out`=0, `gnt_id`=0, `sel`=0, state=EMPTY, round-robin pointer `last`=0. `gnt`=0 while `rst_n`=0.
- Latency: a request in EMPTY is granted in the same cycle; `out_valid`/`d_out` are visible the next cycle.
- Throughput: 1 word/cycle with `out_ready` held high and requests pending.
- `gnt` is combinational from `req`, `out_ready` and state; no register is in that path.
- Reset mid-operation: the held word is discarded immediately (asynchronous). The first edge after release behaves as EMPTY.
- Simultaneous requests: exactly one `gnt` bit is ever high.

## Configuration
- Macro: `PRIORITY_MUX_ARBITER_RR_EN`.
- Undefined: fixed priority as above; `last` is absent.
- Defined: round-robin arbitration.
  - Scan downward from index (`last`-1) mod 6, wrapping 0 -> 5; the first requesting index wins.
  - On each `load`, `last`<=w.
  - With `last`=0 after reset, the first arbitration equals fixed priority.
  - The `sel`/`gnt_id` encodings are unchanged.

## Test plan
- Reset: assert `rst_n`=0 with `req`=6'h3F -> `gnt`=0, `out_valid`=0, `d_out`=0, `sel`=0; release -> the next edge loads source 5.
- Single request: `req`=6'b000100, `d2`=8'hA5, `out_ready`=1 -> `gnt`=6'b000100 that cycle; next cycle `out_valid`=1, `d_out`=8'hA5, `gnt_id`=2, `sel`=5'b00010.
- Stall: FULL holding 8'h11, `out_ready`=0 for 4 cycles while `req`=6'h3F -> `gnt`=0 throughout, `d_out` stays 8'h11; raising `out_ready` loads source 5 in that cycle.
- Back-to-back: `req`=6'h3F, distinct data, `out_ready`=1 for 6 cycles.
  - Fixed: winners 5,5,5,... (sources keep `req` high).
  - RR build: winners 5,4,3,2,1,0, then 5.
- Drain: single word loaded, then `req`=0, `out_ready`=1 -> `out_valid` falls next cycle, `d_out` retains the last word.
- Source 0 encoding: only `req[0]`, `d0`=8'h3C -> `sel`=5'b00000, `gnt_id`=0, `d_out`=8'h3C.

Source files
------------

// File: rtl/priority_mux_arbiter.sv
// Arbitrated front end for a 6-to-1 priority mux chain: picks one requester per cycle and holds
// its word under valid/ready. Define PRIORITY_MUX_ARBITER_RR_EN for round-robin arbitration.
module priority_mux_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  output logic [5:0]       gnt,
  output logic [4:0]       sel,
  output logic [2:0]       gnt_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] d_out_q;
  logic [2:0]       gnt_id_q;
  logic [4:0]       sel_q;

  logic             load;
  logic [2:0]       win;
  logic [4:0]       win_sel;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] src [6];

  assign src[0] = d0;
  assign src[1] = d1;
  assign src[2] = d2;
  assign src[3] = d3;
  assign src[4] = d4;
  assign src[5] = d5;

  // A stalled output blocks every grant; otherwise any request loads.
  assign load = (|req) && ((state_q == StEmpty) || out_ready);

`ifdef PRIORITY_MUX_ARBITER_RR_EN
  logic [2:0] last_q;

  // Scan downward starting just below the previous winner, wrapping 0 -> 5.
  function automatic logic [2:0] rr_pick(input logic [5:0] r, input logic [2:0] last);
    logic [2:0] w   = '0;
    logic       hit = 1'b0;
    int         idx;
    for (int k = 0; k < 6; k++) begin
      idx = int'(last) + 5 - k;
      if (idx >= 6) idx = idx - 6;
      if (!hit && r[3'(idx)]) begin
        w   = 3'(idx);
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  assign win = rr_pick(req, last_q);
`else
  function automatic logic [2:0] fixed_pick(input logic [5:0] r);
    logic [2:0] w = '0;
    for (int i = 0; i < 6; i++) begin
      if (r[i]) w = 3'(i);
    end
    return w;
  endfunction

  assign win = fixed_pick(req);
`endif

  always_comb begin
    win_sel = '0;
    for (int k = 1; k < 6; k++) begin
      if (win == 3'(k)) win_sel[3'(k - 1)] = 1'b1;
    end
  end

  // Same precedence as the external chain, so the captured word matches it for this sel.
  always_comb begin
    win_data = src[0];
    for (int i = 0; i < 5; i++) begin
      if (win_sel[i]) win_data = src[3'(i + 1)];
    end
  end

  assign gnt = (load && rst_n) ? (6'b000001 << win) : 6'b000000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      d_out_q  <= '0;
      gnt_id_q <= '0;
      sel_q    <= '0;
`ifdef PRIORITY_MUX_ARBITER_RR_EN
      last_q   <= '0;
`endif
    end else if (load) begin
      state_q  <= StFull;
      d_out_q  <= win_data;
      gnt_id_q <= win;
      sel_q    <= win_sel;
`ifdef PRIORITY_MUX_ARBITER_RR_EN
      last_q   <= win;
`endif
    end else if (state_q == StFull && out_ready) begin
      state_q <= StEmpty;
    end
  end

  assign out_valid = (state_q == StFull);
  assign d_out     = d_out_q;
  assign gnt_id    = gnt_id_q;
  assign sel       = sel_q;

  a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt));
  a_no_gnt_stalled : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StFull && !out_ready) |-> (gnt == 6'b000000));

endmodule

// File: tb/tb_priority_mux_arbiter.sv
// Directed bench for priority_mux_arbiter: stimulus pushes expected words into a scoreboard
// queue, a monitor pops and compares each word as the consumer takes it.
module tb_priority_mux_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] id;
    logic [4:0] sel;
  } exp_t;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic [5:0]      req       = '0;
  logic [5:0][7:0] dv        = '0;
  logic            out_ready = 1'b0;
  logic [5:0]      gnt;
  logic [4:0]      sel;
  logic [2:0]      gnt_id;
  logic            out_valid;
  logic [7:0]      d_out;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  priority_mux_arbiter #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .d0       (dv[0]),
    .d1       (dv[1]),
    .d2       (dv[2]),
    .d3       (dv[3]),
    .d4       (dv[4]),
    .d5       (dv[5]),
    .gnt      (gnt),
    .sel      (sel),
    .gnt_id   (gnt_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d_out    (d_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0][7:0] pat(input logic [7:0] base);
    logic [5:0][7:0] p;
    for (int i = 0; i < 6; i++) p[i] = 8'(base + 8'(i));
    return p;
  endfunction

  task automatic push(input logic [7:0] d, input logic [2:0] id, input logic [4:0] s);
    exp_t e;
    e.data = d;
    e.id   = id;
    e.sel  = s;
    sb.push_back(e);
  endtask

  // Apply inputs just after the edge, check the combinational grant mid-cycle.
  task automatic step(input logic [5:0] r, input logic rdy, input logic [5:0][7:0] dn,
                      input logic [5:0] eg, input string name);
    @(posedge clk);
    #1;
    req       = r;
    out_ready = rdy;
    dv        = dn;
    @(negedge clk);
    chk(name, 32'(gnt), 32'(eg));
  endtask

  // Monitor: every word taken by the consumer is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL word_unexpected: got d_out=%h gnt_id=%0d sel=%b expected none",
                   d_out, gnt_id, sel);
        end else begin
          e = sb.pop_front();
          chk("word_data", 32'(d_out), 32'(e.data));
          chk("word_id", 32'(gnt_id), 32'(e.id));
          chk("word_sel", 32'(sel), 32'(e.sel));
        end
      end
    end
  end

  initial begin
    logic [5:0][7:0] t;
    logic [4:0]      sel_tab [6];
    logic [2:0]      w;

    sel_tab[0] = 5'b00000;
    sel_tab[1] = 5'b00001;
    sel_tab[2] = 5'b00010;
    sel_tab[3] = 5'b00100;
    sel_tab[4] = 5'b01000;
    sel_tab[5] = 5'b10000;

    // Reset with every source requesting
    req = 6'h3F;
    dv  = pat(8'h10);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_dout", 32'(d_out), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_id", 32'(gnt_id), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'(6'b100000));
    push(8'h15, 3'd5, 5'b10000);
    step(6'h00, 1'b1, pat(8'h10), 6'h00, "post_rst_drain_gnt");

    // Single request from source 2, then drain
    t    = pat(8'h10);
    t[2] = 8'hA5;
    step(6'b000100, 1'b1, t, 6'b000100, "single_gnt");
    push(8'hA5, 3'd2, 5'b00010);
    step(6'h00, 1'b1, t, 6'h00, "single_take_gnt");
    step(6'h00, 1'b0, t, 6'h00, "drain_gnt");
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_dout", 32'(d_out), 32'hA5);

    // Source 0 encoding
    t    = pat(8'h10);
    t[0] = 8'h3C;
    step(6'b000001, 1'b1, t, 6'b000001, "src0_gnt");
    push(8'h3C, 3'd0, 5'b00000);
    step(6'h00, 1'b1, t, 6'h00, "src0_take_gnt");

    // Stall: hold 8'h11 while everyone requests
    t    = pat(8'h10);
    t[1] = 8'h11;
    step(6'b000010, 1'b0, t, 6'b000010, "stall_load_gnt");
    push(8'h11, 3'd1, 5'b00001);
    for (int c = 0; c < 4; c++) begin
      step(6'h3F, 1'b0, pat(8'h20), 6'h00, "stall_gnt");
      chk("stall_dout", 32'(d_out), 32'h11);
      chk("stall_valid", 32'(out_valid), 32'h1);
    end
`ifdef PRIORITY_MUX_ARBITER_RR_EN
    step(6'h3F, 1'b1, pat(8'h20), 6'b000001, "stall_release_gnt");
    push(8'h20, 3'd0, 5'b00000);
`else
    step(6'h3F, 1'b1, pat(8'h20), 6'b100000, "stall_release_gnt");
    push(8'h25, 3'd5, 5'b10000);
`endif

    // Back-to-back with all sources requesting, new data each cycle
    for (int c = 0; c < 7; c++) begin
`ifdef PRIORITY_MUX_ARBITER_RR_EN
      w = (c < 6) ? 3'(5 - c) : 3'd5;
`else
      w = 3'd5;
`endif
      step(6'h3F, 1'b1, pat(8'(8'h40 + 16 * c)), 6'b000001 << w, "b2b_gnt");
      push(8'(8'h40 + 16 * c + int'(w)), w, sel_tab[w]);
    end
    step(6'h00, 1'b1, pat(8'h10), 6'h00, "b2b_drain_gnt");

    // Asynchronous reset while holding a word
    t    = pat(8'h10);
    t[3] = 8'h77;
    step(6'b001000, 1'b0, t, 6'b001000, "pre_rst_gnt");
    @(posedge clk);
    #2;
    req   = 6'h3F;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_dout", 32'(d_out), 32'h0);
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_sel", 32'(sel), 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    dv        = pat(8'h50);
    @(negedge clk);
    chk("rerst_gnt", 32'(gnt), 32'(6'b100000));
    push(8'h55, 3'd5, 5'b10000);
    step(6'h00, 1'b1, pat(8'h50), 6'h00, "rerst_take_gnt");
    step(6'h00, 1'b0, pat(8'h50), 6'h00, "idle_gnt");
    step(6'h00, 1'b0, pat(8'h50), 6'h00, "idle_gnt");

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
